// File: rtl/imem_loader_if.sv
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream receive handshake and instruction-memory write
//               bus shared by the image loader and its host/memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Receives a count-prefixed big-endian word image over a byte
//               stream, writes it to instruction memory, then releases the CPU.
//               Define LOADER_CHECKSUM_EN to append and verify an XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int ADDR_W = 5
) (
    input  wire logic    clock,
    input  wire logic    reset,
    imem_loader_if.slave bus,
    output logic         cpu_run,
    output logic         busy,
    output logic         error
);

    localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        CHK   = 3'd3,
`endif
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t            r_state;
    logic [7:0]        r_words_left;
    logic [1:0]        r_byte_cnt;
    logic [ADDR_W-1:0] r_word_idx;
    logic [23:0]       r_asm;
    logic              r_rx_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_cpu_run;
    logic              r_busy;
    logic              r_error;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_xor;
`endif

    logic w_accept;
    logic w_count_bad;

    assign w_accept    = bus.rx_valid && r_rx_ready;
    assign w_count_bad = (bus.rx_data == 8'd0) || ({24'd0, bus.rx_data} > MAX_WORDS);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_words_left <= 8'd0;
            r_byte_cnt   <= 2'd0;
            r_word_idx   <= '0;
            r_asm        <= 24'd0;
            r_rx_ready   <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_cpu_run    <= 1'b0;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xor        <= 8'd0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_rx_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_count_bad) begin
                            r_state    <= ERR;
                            r_error    <= 1'b1;
                            r_rx_ready <= 1'b0;
                        end else begin
                            r_state      <= DATA;
                            r_words_left <= bus.rx_data;
                            r_byte_cnt   <= 2'd0;
                            r_word_idx   <= '0;
                            r_busy       <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            r_xor        <= 8'd0;
`endif
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_asm      <= {r_asm[15:0], bus.rx_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_xor      <= r_xor ^ bus.rx_data;
`endif
                        // Fourth byte completes the word; present it next cycle.
                        if (r_byte_cnt == 2'd3) begin
                            r_state    <= WRITE;
                            r_we       <= 1'b1;
                            r_addr     <= r_word_idx;
                            r_wdata    <= {r_asm, bus.rx_data};
                            r_rx_ready <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (r_words_left == 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state    <= CHK;
                        r_rx_ready <= 1'b1;
`else
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_cpu_run  <= 1'b1;
`endif
                    end else begin
                        // Index only advances when another word follows, so it never wraps.
                        r_state      <= DATA;
                        r_rx_ready   <= 1'b1;
                        r_words_left <= r_words_left - 8'd1;
                        r_word_idx   <= r_word_idx + ADDR_W'(1);
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (w_accept) begin
                        r_rx_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        if (bus.rx_data == r_xor) begin
                            r_state   <= DONE;
                            r_cpu_run <= 1'b1;
                        end else begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    r_state <= DONE;
                end
                ERR: begin
                    r_state <= ERR;
                end
                default: begin
                    r_state    <= ERR;
                    r_error    <= 1'b1;
                    r_rx_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_cpu_run  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_ready   = r_rx_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign cpu_run        = r_cpu_run;
    assign busy           = r_busy;
    assign error          = r_error;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader; randomized images checked
//               against a frame-level model. Honours LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int AW   = 5;
    localparam int MAXW = 1 << AW;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic cpu_run;
    logic busy;
    logic error;

    int n_tests  = 0;
    int n_fail   = 0;
    int n_writes = 0;

    logic [31:0] img [256];

    imem_loader_if #(.ADDR_W(AW)) u_if ();

    imem_loader #(.ADDR_W(AW)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (u_if.slave),
        .cpu_run (cpu_run),
        .busy    (busy),
        .error   (error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (u_if.imem_we === 1'b1) n_writes++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called and returns at a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax);
        int g;
        int t;
        g = int'($urandom_range(gmax, gmin));
        t = 0;
        repeat (g) begin
            u_if.rx_valid = 1'b0;
            u_if.rx_data  = 8'($urandom);
            @(negedge clock);
        end
        while (u_if.rx_ready !== 1'b1 && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) chk("rx_ready_timeout", 64'(u_if.rx_ready), 64'd1);
        u_if.rx_valid = 1'b1;
        u_if.rx_data  = b;
        @(posedge clock);
        #1;
        u_if.rx_valid = 1'b0;
        u_if.rx_data  = 8'($urandom);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        u_if.rx_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk("rst_rx_ready", 64'(u_if.rx_ready), 64'd0);
        chk("rst_we", 64'(u_if.imem_we), 64'd0);
        chk("rst_addr", 64'(u_if.imem_addr), 64'd0);
        chk("rst_wdata", 64'(u_if.imem_wdata), 64'd0);
        chk("rst_cpu_run", 64'(cpu_run), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_reset", 64'(u_if.rx_ready), 64'd1);
    endtask

    task automatic do_load(input int n, input int gmin, input int gmax, input bit bad_sum);
        int          base;
        bit          bad;
        logic [7:0]  sum;
        logic [7:0]  by;
        base = n_writes;
        bad  = (n == 0) || (n > MAXW);
        sum  = 8'h00;
        send_byte(8'(n), gmin, gmax);
        if (bad) begin
            chk("badcnt_error", 64'(error), 64'd1);
            chk("badcnt_cpu_run", 64'(cpu_run), 64'd0);
            chk("badcnt_rx_ready", 64'(u_if.rx_ready), 64'd0);
            chk("badcnt_busy", 64'(busy), 64'd0);
        end else begin
            chk("busy_after_count", 64'(busy), 64'd1);
            for (int i = 0; i < n; i++) begin
                for (int k = 0; k < 4; k++) begin
                    by  = img[i][8*(3-k) +: 8];
                    sum = sum ^ by;
                    send_byte(by, gmin, gmax);
                end
                chk("write_we", 64'(u_if.imem_we), 64'd1);
                chk("write_addr", 64'(u_if.imem_addr), 64'(i));
                chk("write_data", 64'(u_if.imem_wdata), 64'(img[i]));
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(bad_sum ? (sum ^ 8'h01) : sum, gmin, gmax);
            chk("chk_cpu_run", 64'(cpu_run), bad_sum ? 64'd0 : 64'd1);
            chk("chk_error", 64'(error), bad_sum ? 64'd1 : 64'd0);
`else
            @(negedge clock);
            chk("done_cpu_run", 64'(cpu_run), 64'd1);
            chk("done_error", 64'(error), 64'd0);
`endif
            chk("end_busy", 64'(busy), 64'd0);
            chk("end_rx_ready", 64'(u_if.rx_ready), 64'd0);
            chk("hold_we", 64'(u_if.imem_we), 64'd0);
            chk("hold_addr", 64'(u_if.imem_addr), 64'(n - 1));
            chk("hold_wdata", 64'(u_if.imem_wdata), 64'(img[n-1]));
        end
        repeat (2) @(negedge clock);
        chk("write_count", 64'(n_writes - base), bad ? 64'd0 : 64'(n));
    endtask

    initial begin
        int n;
        int base;
        u_if.rx_valid = 1'b0;
        u_if.rx_data  = 8'h00;

        do_reset();
        img[0] = 32'h8C01_0000;
        img[1] = 32'h0022_1820;
        do_load(2, 0, 0, 1'b0);

        do_reset();
        do_load(2, 3, 3, 1'b0);

        do_reset();
        for (int i = 0; i < MAXW; i++) img[i] = $urandom;
        do_load(MAXW, 0, 1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            do_reset();
            n = int'($urandom_range(MAXW - 1, 1));
            for (int i = 0; i < n; i++) img[i] = $urandom;
            do_load(n, 0, 2, 1'b0);
        end

        do_reset();
        do_load(0, 0, 0, 1'b0);
        do_reset();
        do_load(MAXW + 1, 0, 0, 1'b0);
        do_reset();
        do_load(int'($urandom_range(255, MAXW + 2)), 0, 1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        img[0] = 32'h1234_5678;
        do_reset();
        do_load(1, 0, 0, 1'b0);
        do_reset();
        do_load(1, 0, 0, 1'b1);
`endif

        // Abort after the second byte of word 1.
        do_reset();
        img[0] = $urandom;
        img[1] = $urandom;
        base   = n_writes;
        send_byte(8'd2, 0, 0);
        for (int k = 0; k < 4; k++) send_byte(img[0][8*(3-k) +: 8], 0, 0);
        send_byte(img[1][31:24], 0, 0);
        send_byte(img[1][23:16], 0, 0);
        do_reset();
        chk("abort_write_count", 64'(n_writes - base), 64'd1);
        img[0] = $urandom;
        do_load(1, 0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 5, sets the instruction-memory word-address width; the maximum image size is 2^ADDR_W words.
REQ-002 Port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1, asynchronous active-low reset.
REQ-004 Port rx_data, input, 8, incoming image byte.
REQ-005 Port rx_valid, input, 1, rx_data is valid.
REQ-006 Port rx_ready, output, 1, loader can accept a byte this cycle.
REQ-007 Port imem_we, output, 1, instruction-memory write strobe.
REQ-008 Port imem_addr, output, ADDR_W, instruction-memory word address.
REQ-009 Port imem_wdata, output, 32, instruction word to write.
REQ-010 Port cpu_run, output, 1, high releases the CPU from reset; it is driven straight to the CPU reset input.
REQ-011 Port busy, output, 1, high while a load is in progress.
REQ-012 Port error, output, 1, the load failed; sticky until reset.

Function
REQ-013 A byte is accepted only on a rising edge where rx_valid and rx_ready are both high.
- rx_data is ignored at all other times.
REQ-014 The frame format is as follows.
- Byte 0 is the word count N.
- Then come N words of 4 bytes each, sent MSB first (big-endian).
- With LOADER_CHECKSUM_EN defined, one checksum byte follows the words.
REQ-015 The FSM states are IDLE, DATA, WRITE, CHK, DONE and ERR.
REQ-016 IDLE: rx_ready=1, busy=0.
- On accepting the count, N=0 or N>2^ADDR_W goes to ERR.
- Any other N latches N, clears the byte and word counters, and goes to DATA.
REQ-017 DATA: rx_ready=1, busy=1.
- Each accepted byte is shifted into a 32-bit assembly register, first byte landing in bits 31:24.
- On the 4th byte of a word the FSM goes to WRITE.
REQ-018 WRITE lasts exactly one cycle.
- rx_ready=0 and imem_we=1.
- imem_addr is the current word index and imem_wdata is the assembled word.
- The word index then increments.
REQ-019 Exit from WRITE:
- If words remain, go to DATA.
- After word N-1: go to DONE without the macro, or to CHK with it.
REQ-020 Write latency is one cycle: imem_we is high in the cycle after the edge that accepted the word's 4th byte.
REQ-021 Word indices run 0..N-1 with no wrap. N=2^ADDR_W writes the top address last; the index never wraps back to 0.
REQ-022 imem_we is 0 in every state except WRITE.
- imem_addr and imem_wdata hold their last values when imem_we=0.
REQ-023 DONE: cpu_run=1, rx_ready=0, busy=0. DONE is held until reset, so one load is performed per reset.
REQ-024 ERR: error=1, cpu_run=0, rx_ready=0, busy=0. ERR is held until reset.
REQ-025 cpu_run is 0 in every state except DONE, so the CPU stays in reset throughout loading.
REQ-026 Incoming bytes stall indefinitely without timeout; gaps in rx_valid do not corrupt byte alignment.

Reset
REQ-027 reset=0 asynchronously forces the following:
- state IDLE and all counters 0;
- imem_we=0, imem_addr=0, imem_wdata=0;
- cpu_run=0, busy=0, error=0;
- rx_ready=0 while reset is low.
REQ-028 After reset deasserts, rx_ready=1 from the first rising edge.
REQ-029 Reset asserted mid-load aborts the load immediately, with no further writes. Memory contents already written are left untouched.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined:
- A running XOR is kept over all data bytes; the count byte is excluded.
- CHK has rx_ready=1 and busy=1.
- An accepted byte equal to the XOR goes to DONE; any other value goes to ERR.
REQ-031 Macro LOADER_CHECKSUM_EN undefined: no CHK state and no XOR logic exist, and WRITE for the last word goes directly to DONE.

Verification
REQ-032 Reset: hold reset=0 for 4 cycles -> all outputs are 0, including rx_ready; cpu_run=0.
REQ-033 Basic load (macro undefined): send 02, 8C 01 00 00, 00 22 18 20 with rx_valid continuous ->
- imem_we pulses at addr 0 with 8C010000, then at addr 1 with 00221820;
- cpu_run=1 on the cycle after the second write.
REQ-034 Full size and bad count:
- N=32 with ADDR_W=5 -> 32 writes to addr 0..31, then DONE.
- N=0 -> error=1 with no write.
- N=33 -> error=1 with no write.
REQ-035 Stalls: same image as REQ-033, with rx_valid low for 3 cycles between every byte -> identical writes and data; no writes occur during the gaps.
REQ-036 Checksum (macro defined): image 01, 12 34 56 78.
- Checksum 08 -> DONE with cpu_run=1.
- Checksum 09 -> error=1 with cpu_run=0.
REQ-037 Abort: pull reset=0 after the 2nd byte of word 1 -> no further imem_we; after release, a fresh 1-word load succeeds.
